// File: rtl/tlul_rr_arbiter.sv
`default_nettype none
// tlul_rr_arbiter: round-robin merge of NUM_HOSTS TL-UL A channels onto one downstream port,
// with an in-order source-ID FIFO that steers each D response back to its issuing host.
module tlul_rr_arbiter #(
   parameter int NUM_HOSTS       = 2,
   parameter int ADDR_W          = 12,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_HOSTS-1:0]                 h_a_valid_i,
   input  logic [3*NUM_HOSTS-1:0]               h_a_opcode_i,
   input  logic [ADDR_W*NUM_HOSTS-1:0]          h_a_address_i,
   input  logic [DATA_W*NUM_HOSTS-1:0]          h_a_data_i,
   output logic [NUM_HOSTS-1:0]                 h_a_ready_o,
   output logic [NUM_HOSTS-1:0]                 h_d_valid_o,
   output logic [2:0]                           h_d_opcode_o,
   output logic [DATA_W-1:0]                    h_d_data_o,
   input  logic [NUM_HOSTS-1:0]                 h_d_ready_i,
   output logic                                 dn_a_valid_o,
   output logic [2:0]                           dn_a_opcode_o,
   output logic [ADDR_W-1:0]                    dn_a_address_o,
   output logic [DATA_W-1:0]                    dn_a_data_o,
   input  logic                                 dn_a_ready_i,
   input  logic                                 dn_d_valid_i,
   input  logic [2:0]                           dn_d_opcode_i,
   input  logic [DATA_W-1:0]                    dn_d_data_i,
   output logic                                 dn_d_ready_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 err_o
);
   localparam int IW = $clog2(NUM_HOSTS);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);
   localparam logic [IW-1:0] HOST_LAST = IW'(NUM_HOSTS - 1);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic [IW-1:0] fifo_q [MAX_OUTSTANDING];

   logic [IW-1:0] win;
   logic [IW-1:0] head;
   logic          fifo_empty, fifo_full;
   logic          a_req, a_fire, d_fire;

   // Search upward from rr_ptr for the first requester; a held grant overrides the search.
   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      found = 1'b0;
      idx   = '0;
      win   = rr_ptr_q;
      for (int k = 0; k < NUM_HOSTS; k++) begin
         idx = IW'((int'(rr_ptr_q) + k) % NUM_HOSTS);
         if (!found && h_a_valid_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (lock_q) win = lock_idx_q;
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_MAX);
   assign head       = fifo_q[rd_ptr_q];

   assign a_req  = (|h_a_valid_i) & ~fifo_full;
   assign a_fire = a_req & dn_a_ready_i;
   assign d_fire = dn_d_valid_i & ~fifo_empty & h_d_ready_i[head];

   assign dn_a_valid_o   = reset & a_req;
   assign dn_a_opcode_o  = h_a_opcode_i[3*int'(win) +: 3];
   assign dn_a_address_o = h_a_address_i[ADDR_W*int'(win) +: ADDR_W];
   assign dn_a_data_o    = h_a_data_i[DATA_W*int'(win) +: DATA_W];
   assign h_a_ready_o    = (reset & a_fire) ? (NUM_HOSTS'(1) << win) : '0;

   assign h_d_valid_o  = (!fifo_empty && dn_d_valid_i) ? (NUM_HOSTS'(1) << head) : '0;
   assign h_d_opcode_o = dn_d_opcode_i;
   assign h_d_data_o   = dn_d_data_i;
   // With nothing outstanding the beat is swallowed so the downstream cannot wedge.
   assign dn_d_ready_o = fifo_empty ? (reset & dn_d_valid_i) : h_d_ready_i[head];

   assign outstanding_o = count_q;
   assign err_o         = err_q;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = a_req & ~dn_a_ready_i;
      lock_idx_d = lock_idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + CW'(a_fire) - CW'(d_fire);
      err_d      = err_q | (dn_d_valid_i & fifo_empty);
      if (lock_d) lock_idx_d = win;
      if (a_fire) begin
         rr_ptr_d = (win == HOST_LAST) ? '0 : win + 1'b1;
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (d_fire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   // Source-ID storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (a_fire) fifo_q[wr_ptr_q] <= win;
   end

endmodule
`default_nettype wire

// File: doc/tlul_rr_arbiter.md
# tlul_rr_arbiter

Parametrised TileLink-UL host arbiter placed between the RV32I core's bus ports and the shared memory/peripheral slave. It merges NUM_HOSTS request channels (instruction fetch, data load/store, and later DMA or debug) onto one downstream A channel using round-robin arbitration. It tracks up to MAX_OUTSTANDING in-flight transactions in a source-ID FIFO and returns each in-order D response to the host that issued the request.

## Interface
- NUM_HOSTS, default 2: number of upstream hosts (2..8).
- ADDR_W, default 12: address width.
- DATA_W, default 32: data width.
- MAX_OUTSTANDING, default 4: source-ID FIFO depth (1..16).
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- h_a_valid_i  input  NUM_HOSTS  per-host A request valid.
- h_a_opcode_i  input  3*NUM_HOSTS  per-host opcode. 3'b100 is Get, 3'b000 is PutFullData. Host i occupies bits [3i+2:3i].
- h_a_address_i  input  ADDR_W*NUM_HOSTS  per-host address, packed the same way.
- h_a_data_i  input  DATA_W*NUM_HOSTS  per-host write data.
- h_a_ready_o  output  NUM_HOSTS  per-host A accept.
- h_d_valid_o  output  NUM_HOSTS  per-host D response valid.
- h_d_opcode_o  output  3  D opcode broadcast to all hosts. 3'b001 is AccessAckData, 3'b000 is AccessAck.
- h_d_data_o  output  DATA_W  D data broadcast to all hosts.
- h_d_ready_i  input  NUM_HOSTS  per-host D accept.
- dn_a_valid_o, dn_a_opcode_o[2:0], dn_a_address_o[ADDR_W-1:0], dn_a_data_o[DATA_W-1:0]  output  downstream A channel.
- dn_a_ready_i  input  1  downstream A accept.
- dn_d_valid_i, dn_d_opcode_i[2:0], dn_d_data_i[DATA_W-1:0]  input  downstream D channel.
- dn_d_ready_o  output  1  downstream D accept.
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  count of in-flight transactions.
- err_o  output  1  sticky flag: a D beat arrived with no outstanding transaction.

## Operation
- **Handshakes.** An A beat transfers when valid and ready are both 1 in the same cycle. The same rule applies to D beats.
- **Arbitration.** The winner is the first host with h_a_valid_i=1, searching from rr_ptr upward and wrapping modulo NUM_HOSTS.
  - After an accepted A beat, rr_ptr becomes (winner+1) mod NUM_HOSTS.
  - A rejected beat leaves rr_ptr unchanged.
- **Grant lock.** Once dn_a_valid_o is asserted for a winner and not yet accepted, that grant is held. The winner and all dn_a_* payload stay stable until dn_a_ready_i=1, even if a higher-priority host raises valid.
  - The grant lock is a registered flag plus a registered winner index.
- **A forwarding.**
  - dn_a_valid_o = any h_a_valid_i AND count < MAX_OUTSTANDING.
  - The dn_a payload is the winner's payload.
  - h_a_ready_o[winner] = dn_a_ready_i AND dn_a_valid_o. All other h_a_ready_o bits are 0.
- **Source FIFO.**
  - Push: the winner index is pushed on every accepted A beat.
  - Pop: the FIFO is popped on every accepted D beat.
  - Pointers are $clog2(MAX_OUTSTANDING) bits and wrap at MAX_OUTSTANDING. This holds for non-power-of-2 depths.
  - Push and pop in the same cycle leave count unchanged.
  - When full, A is stalled even if a pop occurs in the same cycle; there is no bypass.
- **D routing.**
  - With FIFO non-empty, h = head index:
    - h_d_valid_o[h] = dn_d_valid_i. All other h_d_valid_o bits are 0.
    - dn_d_ready_o = h_d_ready_i[h].
  - With FIFO empty and dn_d_valid_i=1: dn_d_ready_o=1 (the beat is drained) and err_o is set. err_o clears only on reset.
- **Ordering.** Downstream responds in request order, so no reordering is needed.

## Timing
- **A path.** Combinational pass-through from host to downstream, zero added cycles. The grant-lock register affects only the next cycle.
- **D path.** Combinational from downstream to host, zero added cycles.
- **Counts.** outstanding_o and the FIFO pointers update on the clock edge following a handshake.
- **Back-to-back throughput.** One A beat per cycle while not full, and one D beat per cycle.
- **Reset values.** reset low clears, immediately and regardless of clk:
  - rr_ptr=0, grant lock released, FIFO empty, outstanding_o=0, err_o=0.
  - All valid/ready outputs 0 while reset is low, because FIFO empty forces h_d_valid_o=0 and the A path is gated by reset.
- **Reset mid-operation.** In-flight transactions are discarded. Any later D beat for them sets err_o.

## Test plan
- **Round-robin.** NUM_HOSTS=2, both hosts valid continuously, dn_a_ready_i=1, D returned 1 cycle later. Required: grants alternate 0,1,0,1. Each host's D data matches its issued address tag (e.g. host0 Get 0x010 -> d 0xAAAA0010, host1 Get 0x020 -> 0xBBBB0020).
- **Grant lock.** Host1 granted and dn_a_ready_i=0 for 3 cycles while host0 raises valid. Required: dn_a_address_o stays at host1's 0x044 for all 3 cycles; host0 is granted in the cycle after acceptance.
- **Full stall.** MAX_OUTSTANDING=4, 4 Gets accepted, no D. Required: outstanding_o=4 and dn_a_valid_o=0. After one D handshake, outstanding_o=3 and A resumes the next cycle.
- **Ordered routing.** Issue host0, host1, host1, host0 with D held back, then release D in order with data 1,2,3,4. Required: h_d_valid_o sequence is 01,10,10,01 (bit 0 = host 0) and dn_d_ready_o follows each host's h_d_ready_i, including a 2-cycle host1 backpressure.
- **Spurious D.** dn_d_valid_i=1 with FIFO empty. Required: dn_d_ready_o=1, no h_d_valid_o bit set, err_o=1 from the next edge until reset.
- **Async reset.** Assert reset low mid-cycle with 2 transactions outstanding. Required: outstanding_o=0 and err_o=0 immediately, without waiting for a clk edge. After release, the first grant goes to host 0.
